// File: rtl/tc_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tc_fetch_pkg
// Purpose : Shared types and constants for the ROM prefetch front end.
//           Holds the fetch FSM state encoding, the ROM size-query address
//           and the fetch word size in bytes.
// Revision: 1.0 - initial release
// ============================================================================
package tc_fetch_pkg;

  typedef enum logic [1:0] {
    SIZE_REQ  = 2'd0,
    SIZE_WAIT = 2'd1,
    FETCH     = 2'd2,
    DONE      = 2'd3
  } fetch_state_t;

  // Reading this address returns the file size instead of file data.
  localparam logic [63:0] ROM_SIZE_ADDR = 64'hFFFF_FFFF_FFFF_FFFF;

  localparam logic [63:0] WORD_BYTES = 64'd8;

endpackage : tc_fetch_pkg
`default_nettype wire

// File: rtl/tc_fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module  : tc_fetch_fifo
// Purpose : Synchronous FIFO for fetched words. Supports push and pop in the
//           same cycle (including when full), a flush that empties it in one
//           cycle, and an occupancy count used for fetch credit accounting.
// Ports   : clk, rst (async, active-high)
//           flush              - discard all entries (wins over push)
//           push, push_data    - write one entry
//           pop                - remove the head entry (ignored when empty)
//           pop_data           - current head entry
//           empty, count       - occupancy status
// Revision: 1.0 - initial release
// ============================================================================
module tc_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_pop;
  logic             do_push;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  // A full FIFO can still accept a word when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule : tc_fetch_fifo
`default_nettype wire

// File: rtl/tc_rom_prefetch.sv
`default_nettype none
// ============================================================================
// Module  : tc_rom_prefetch
// Purpose : Fetch front end behind a registered, byte-addressed file ROM.
//           After reset it queries the file size, then streams 8-byte words
//           from RESET_PC upward into a small FIFO and hands them to decode
//           over valid/ready. Redirects flush buffered and in-flight words
//           and restart fetching at the new address.
// Ports   : clk, rst (async, active-high)
//           rom_en, rom_address   - registered ROM read request
//           rom_data              - ROM data, valid the cycle after rom_en
//           redirect_valid/addr   - flush and refetch from redirect_addr
//           out_valid/ready       - decode handshake
//           out_data/pc/last      - head word, its byte address, end-of-file
//           size_valid, file_size - captured file size
// Revision: 1.0 - initial release
// ============================================================================
module tc_rom_prefetch
  import tc_fetch_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [63:0] RESET_PC   = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rom_en,
  output logic [63:0] rom_address,
  input  logic [63:0] rom_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [63:0] out_pc,
  output logic        out_last,
  output logic        size_valid,
  output logic [63:0] file_size
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t  state;
  logic [63:0]   fetch_pc;
  // Marks that rom_data carries a response to a live request this cycle.
  // Cleared by a redirect so the response to a killed request is dropped.
  logic          resp_valid;
  logic [63:0]   resp_pc;

  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  logic [127:0]  fifo_head;

  logic          fetching;
  logic          pop;
  logic          push;
  logic          flush;
  logic [CW:0]   credits;
  logic [CW:0]   credit_limit;
  logic          can_issue;
  logic [63:0]   next_pc;
  logic [63:0]   start_pc;

  assign fetching = (state == FETCH) || (state == DONE);
  assign pop      = out_valid && out_ready;
  assign flush    = fetching && redirect_valid;
  assign push     = fetching && resp_valid && !redirect_valid;

  // Buffered words plus requests still travelling through the ROM. A pop this
  // cycle frees a slot before the new request's data can arrive.
  assign credits      = {1'b0, fifo_count} + (CW+1)'(rom_en) + (CW+1)'(resp_valid);
  assign credit_limit = (CW+1)'(FIFO_DEPTH) + (CW+1)'(pop);
  assign can_issue    = (credits < credit_limit);

  assign next_pc  = fetch_pc + WORD_BYTES;
  // A redirect during the size query replaces the start address.
  assign start_pc = redirect_valid ? redirect_addr : fetch_pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= SIZE_REQ;
      rom_en      <= 1'b0;
      rom_address <= '0;
      fetch_pc    <= RESET_PC;
      file_size   <= '0;
      size_valid  <= 1'b0;
      resp_valid  <= 1'b0;
      resp_pc     <= '0;
    end else begin
      rom_en     <= 1'b0;
      resp_valid <= rom_en;
      resp_pc    <= rom_address;
      case (state)
        SIZE_REQ: begin
          rom_en      <= 1'b1;
          rom_address <= ROM_SIZE_ADDR;
          state       <= SIZE_WAIT;
          if (redirect_valid) begin
            fetch_pc <= redirect_addr;
          end
        end
        SIZE_WAIT: begin
          if (redirect_valid) begin
            fetch_pc <= redirect_addr;
          end
          if (resp_valid) begin
            file_size  <= rom_data;
            size_valid <= 1'b1;
            state      <= (start_pc >= rom_data) ? DONE : FETCH;
          end
        end
        FETCH, DONE: begin
          if (redirect_valid) begin
            resp_valid <= 1'b0;
            fetch_pc   <= redirect_addr;
            state      <= (redirect_addr >= file_size) ? DONE : FETCH;
          end else if (state == FETCH && can_issue) begin
            rom_en      <= 1'b1;
            rom_address <= fetch_pc;
            fetch_pc    <= next_pc;
            // The all-ones size address is never reached as a data fetch
            // because it is never below file_size.
            if (next_pc >= file_size) begin
              state <= DONE;
            end
          end
        end
        default: state <= SIZE_REQ;
      endcase
    end
  end

  tc_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (128)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data ({resp_pc, rom_data}),
    .pop       (pop),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign out_pc    = fifo_head[127:64];
  assign out_data  = fifo_head[63:0];
  // 65-bit compare so a pc near the top of the address space cannot wrap.
  assign out_last  = (({1'b0, out_pc} + 65'd8) >= {1'b0, file_size});

endmodule : tc_rom_prefetch
`default_nettype wire

// File: tb/tb_tc_rom_prefetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_tc_rom_prefetch
// Purpose : Self-checking bench for tc_rom_prefetch with a registered ROM
//           model, a word-stream reference model and directed corner cases.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tc_rom_prefetch;

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rom_en;
  logic [63:0] rom_address;
  logic [63:0] rom_data = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_addr = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_data;
  logic [63:0] out_pc;
  logic        out_last;
  logic        size_valid;
  logic [63:0] file_size;

  always #5 clk = ~clk;

  tc_rom_prefetch #(.FIFO_DEPTH(4), .RESET_PC(64'd0)) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_en         (rom_en),
    .rom_address    (rom_address),
    .rom_data       (rom_data),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_pc         (out_pc),
    .out_last       (out_last),
    .size_valid     (size_valid),
    .file_size      (file_size)
  );

  typedef struct {
    logic [63:0] size;
    bit          rand_ready;
    int          exp_words;
    logic [63:0] exp_last_pc;
  } vec_t;

  vec_t        vecs[6];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] rom_size = 64'd302;
  bit          rand_ready = 1'b0;
  logic [63:0] exp_q[$];
  logic [63:0] req_q[$];
  logic [63:0] pop_q[$];
  int          words_out = 0;
  logic [63:0] last_flag_pc = ALL1;
  logic [63:0] mon_pc;

  // File contents: an arbitrary byte pattern derived from the address.
  function automatic logic [7:0] mem_byte(input logic [63:0] a);
    return a[7:0] ^ a[15:8] ^ {a[4:0], a[7:5]} ^ 8'h5A;
  endfunction

  function automatic logic [63:0] mem_word(input logic [63:0] a);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[i*8 +: 8] = mem_byte(a + 64'(i));
    return w;
  endfunction

  // Expected stream: every 8-byte step from the start address below the size.
  function automatic void build_exp(input logic [63:0] start);
    logic [63:0] pc;
    exp_q.delete();
    pc = start;
    while (pc < rom_size) begin
      exp_q.push_back(pc);
      pc = pc + 64'd8;
      if (pc < 64'd8) break;
    end
  endfunction

  // Registered ROM: answers the cycle after a request.
  always @(posedge clk) begin
    if (rom_en) rom_data <= (rom_address == ALL1) ? rom_size : mem_word(rom_address);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rom_en) begin
        req_q.push_back(rom_address);
        if (rom_address != ALL1) chk("req_in_range", 64'(rom_address < rom_size), 64'd1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got pc %h expected no word", out_pc);
        end else begin
          mon_pc = exp_q.pop_front();
          chk("out_pc", out_pc, mon_pc);
          chk("out_data", out_data, mem_word(mon_pc));
          chk("out_last", 64'(out_last), 64'(({1'b0, mon_pc} + 65'd8) >= {1'b0, rom_size}));
          pop_q.push_back(out_pc);
          words_out++;
          if (out_last) last_flag_pc = out_pc;
        end
      end
      if (redirect_valid) begin
        build_exp(redirect_addr);
        pop_q.delete();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic release_rst();
    rst = 1'b0;
    req_q.delete();
    pop_q.delete();
    words_out    = 0;
    last_flag_pc = ALL1;
    build_exp(64'd0);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    release_rst();
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < max) begin
      tick();
      n++;
    end
    if (n >= max) chk("drain_timeout", 64'(n), 64'(max - 1));
  endtask

  task automatic wait_reqs(input int want, input int max);
    int n = 0;
    while (req_q.size() < want && n < max) begin
      tick();
      n++;
    end
    if (n >= max) chk("req_timeout", 64'(req_q.size()), 64'(want));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    vecs[0] = '{size: 64'd302, rand_ready: 1'b0, exp_words: 38, exp_last_pc: 64'd296};
    vecs[1] = '{size: 64'd302, rand_ready: 1'b1, exp_words: 38, exp_last_pc: 64'd296};
    vecs[2] = '{size: 64'd8,   rand_ready: 1'b0, exp_words: 1,  exp_last_pc: 64'd0};
    vecs[3] = '{size: 64'd9,   rand_ready: 1'b1, exp_words: 2,  exp_last_pc: 64'd8};
    vecs[4] = '{size: 64'd0,   rand_ready: 1'b0, exp_words: 0,  exp_last_pc: ALL1};
    vecs[5] = '{size: 64'd64,  rand_ready: 1'b1, exp_words: 8,  exp_last_pc: 64'd56};

    // Reset values
    #1 rst = 1'b1;
    #1;
    chk("rst_rom_en", 64'(rom_en), 64'd0);
    chk("rst_rom_address", rom_address, 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_size_valid", 64'(size_valid), 64'd0);
    chk("rst_file_size", file_size, 64'd0);

    // Streaming table
    for (int i = 0; i < 6; i++) begin
      rom_size   = vecs[i].size;
      rand_ready = vecs[i].rand_ready;
      out_ready  = 1'b1;
      do_reset();
      drain(3000);
      repeat (8) tick();
      chk("words", 64'(words_out), 64'(vecs[i].exp_words));
      chk("last_pc", last_flag_pc, vecs[i].exp_last_pc);
      chk("first_req", (req_q.size() > 0) ? req_q[0] : 64'd0, ALL1);
      chk("data_reqs", 64'(req_q.size() - 1), 64'(vecs[i].exp_words));
      chk("size_valid", 64'(size_valid), 64'd1);
      chk("file_size", file_size, vecs[i].size);
      chk("idle_rom_en", 64'(rom_en), 64'd0);
    end

    // Consumer stalled from the start: credits cap the requests
    rom_size = 64'd302; rand_ready = 1'b0; out_ready = 1'b0;
    do_reset();
    repeat (30) tick();
    chk("stall_reqs", 64'(req_q.size()), 64'd5);
    for (int i = 1; i < 5 && i < req_q.size(); i++) chk("stall_addr", req_q[i], 64'((i - 1) * 8));
    chk("stall_rom_en", 64'(rom_en), 64'd0);
    chk("stall_valid", 64'(out_valid), 64'd1);
    chk("stall_pc", out_pc, 64'd0);
    out_ready = 1'b1;
    wait_reqs(6, 20);
    if (req_q.size() > 5) chk("resume_addr", req_q[5], 64'd32);
    drain(500);

    // Redirect in the cycle the response for pc 40 returns
    rom_size = 64'd302; out_ready = 1'b1;
    do_reset();
    n = 0;
    while (!(rom_en && rom_address == 64'd40) && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("req40_timeout", 64'(n), 64'd0);
    tick();
    redirect_valid = 1'b1;
    redirect_addr  = 64'h13;
    tick();
    chk("redir_out_valid", 64'(out_valid), 64'd0);
    chk("redir_rom_en", 64'(rom_en), 64'd0);
    tick();
    chk("redir_req_en", 64'(rom_en), 64'd1);
    chk("redir_req_addr", rom_address, 64'h13);
    n = 0;
    while (pop_q.size() < 2 && n < 50) begin
      tick();
      n++;
    end
    chk("redir_pop0", (pop_q.size() > 0) ? pop_q[0] : ALL1, 64'h13);
    chk("redir_pop1", (pop_q.size() > 1) ? pop_q[1] : ALL1, 64'h1B);
    drain(500);

    // Redirect during the size query
    rom_size = 64'd302;
    do_reset();
    n = 0;
    while (!(rom_en && rom_address == ALL1) && n < 20) begin
      tick();
      n++;
    end
    redirect_valid = 1'b1;
    redirect_addr  = 64'd100;
    wait_reqs(2, 20);
    chk("size_redir_req", (req_q.size() > 1) ? req_q[1] : ALL1, 64'd100);
    drain(500);

    // Redirect beyond the file end
    rom_size = 64'd302;
    do_reset();
    repeat (12) tick();
    redirect_valid = 1'b1;
    redirect_addr  = 64'd400;
    tick();
    bad = 0;
    repeat (20) begin
      if (rom_en || out_valid) bad++;
      tick();
    end
    chk("past_end_idle", 64'(bad), 64'd0);

    // Asynchronous reset mid-fetch
    rom_size = 64'd302; rand_ready = 1'b1;
    do_reset();
    repeat (15) tick();
    #2 rst = 1'b1;
    #1;
    chk("async_rom_en", 64'(rom_en), 64'd0);
    chk("async_rom_address", rom_address, 64'd0);
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_size_valid", 64'(size_valid), 64'd0);
    chk("async_file_size", file_size, 64'd0);
    @(posedge clk);
    #1;
    release_rst();
    wait_reqs(1, 20);
    chk("async_first_req", (req_q.size() > 0) ? req_q[0] : 64'd0, ALL1);
    drain(3000);
    chk("async_words", 64'(words_out), 64'd38);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_tc_rom_prefetch
`default_nettype wire
